// File: rtl/seg_pkg.sv
// Shared definitions for the two-digit seven-segment scan driver:
// scan states and active-high segment patterns in {g,f,e,d,c,b,a} order.
`default_nettype none

package seg_pkg;

    typedef enum logic [1:0] {
        SHOW_U = 2'd0,
        GAP_U  = 2'd1,
        SHOW_T = 2'd2,
        GAP_T  = 2'd3
    } scan_state_e;

    localparam logic [6:0] SEG_OFF  = 7'b0000000;
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

endpackage

`default_nettype wire

// File: rtl/seven_seg_mux_if.sv
// Digit inputs from the counter stage and the registered display pin outputs.
`default_nettype none

interface seven_seg_mux_if;
    logic [3:0] iUnits;
    logic [3:0] iTens;
    logic [6:0] oSeg;
    logic [1:0] oDigit;
    logic       oFrame;

    modport master (output iUnits, output iTens,
                    input  oSeg,   input  oDigit, input oFrame);

    modport slave  (input  iUnits, input  iTens,
                    output oSeg,   output oDigit, output oFrame);
endinterface

`default_nettype wire

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-high seven-segment decoder; codes 10-15 show a dash.
`default_nettype none

module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seven_seg_mux.sv
// Two-digit time-multiplexed seven-segment driver: frame-latched digits,
// blanking gaps between digits, registered pin outputs with selectable polarity.
`default_nettype none

module seven_seg_mux
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic               iClk,
    input  logic               iRst_n,
    seven_seg_mux_if.slave     bus
);

    localparam int              PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [6:0]      SEG_POL    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0]      DIG_POL    = (DIG_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    logic [PW-1:0] presc_q, presc_d;
    scan_state_e   state_q, state_d;
    logic [3:0]    units_q, units_d;
    logic [3:0]    tens_q,  tens_d;
    logic [6:0]    seg_q,   seg_d;
    logic [1:0]    digit_q, digit_d;
    logic          frame_q, frame_d;

    logic          w_slot_tick;
    logic          w_frame_start;
    logic [3:0]    w_dec_in;
    logic [6:0]    w_dec_seg;

    // State register: prescaler, scan state, digit latches and pin registers
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            presc_q <= '0;
            state_q <= GAP_T;
            units_q <= 4'd0;
            tens_q  <= 4'd0;
            seg_q   <= SEG_OFF ^ SEG_POL;
            digit_q <= 2'b00 ^ DIG_POL;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            state_q <= state_d;
            units_q <= units_d;
            tens_q  <= tens_d;
            seg_q   <= seg_d;
            digit_q <= digit_d;
            frame_q <= frame_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_slot_tick = (presc_q == PRESC_LAST);
        presc_d     = w_slot_tick ? '0 : presc_q + 1'b1;
        state_d     = state_q;
        if (w_slot_tick) begin
            case (state_q)
                SHOW_U:  state_d = GAP_U;
                GAP_U:   state_d = SHOW_T;
                SHOW_T:  state_d = GAP_T;
                default: state_d = SHOW_U;
            endcase
        end
        w_frame_start = w_slot_tick && (state_q == GAP_T);
        units_d       = w_frame_start ? bus.iUnits : units_q;
        tens_d        = w_frame_start ? bus.iTens  : tens_q;
        frame_d       = w_frame_start;
    end

    // Outputs are computed from the upcoming state and latches so the pins
    // change on the same edge as the scan state.
    assign w_dec_in = (state_d == SHOW_T) ? tens_d : units_d;

    bcd_to_seg u_dec (
        .bcd_i (w_dec_in),
        .seg_o (w_dec_seg)
    );

    always_comb begin
        seg_d   = SEG_OFF;
        digit_d = 2'b00;
        case (state_d)
            SHOW_U: begin
                seg_d   = w_dec_seg;
                digit_d = 2'b01;
            end
            SHOW_T: begin
                if (!((BLANK_LEADING != 0) && (tens_d == 4'd0))) begin
                    seg_d   = w_dec_seg;
                    digit_d = 2'b10;
                end
            end
            default: begin
                seg_d   = SEG_OFF;
                digit_d = 2'b00;
            end
        endcase
        seg_d   = seg_d ^ SEG_POL;
        digit_d = digit_d ^ DIG_POL;
    end

    assign bus.oSeg   = seg_q;
    assign bus.oDigit = digit_q;
    assign bus.oFrame = frame_q;

endmodule

`default_nettype wire

// File: doc/seven_seg_mux.md
# seven_seg_mux

- Drives a two-digit, time-multiplexed seven-segment display from the units/tens BCD digits produced by the upstream 00–99 counter.
- Samples both digits once per display frame, so a count change never tears across digits.
- Decodes BCD to segments and scans the two digit enables with a blanking gap between digits to suppress ghosting.
- Sits between the counter stage and the board pins; all outputs are registered.

## Interface
- REFRESH_DIV, 50000 — clock cycles per scan slot; legal range ≥ 2.
- SEG_ACTIVE_LOW, 1 — 1: segment lit = 0; 0: segment lit = 1.
- DIG_ACTIVE_LOW, 1 — 1: digit enabled = 0; 0: digit enabled = 1.
- BLANK_LEADING, 1 — 1: tens digit dark when the latched tens value is 0.
- iClk  input  1  system clock, rising edge.
- iRst_n  input  1  asynchronous reset, active-low.
- iUnits  input  4  units BCD digit from the counter stage.
- iTens  input  4  tens BCD digit from the counter stage.
- oSeg  output  7  segments, bit order {g,f,e,d,c,b,a}.
- oDigit  output  2  digit enables; bit0 = units, bit1 = tens.
- oFrame  output  1  one-cycle pulse on every frame start (new digits latched).

## Operation
- Prescaler: counts 0..REFRESH_DIV-1 and wraps.
  - Slot tick = prescaler equals REFRESH_DIV-1 at a rising edge.
  - Prescaler width = clog2(REFRESH_DIV).
- Scan FSM advances only on a slot tick, in a fixed cycle:
  - SHOW_U → GAP_U → SHOW_T → GAP_T → SHOW_U.
- Entering SHOW_U is the frame start:
  - iUnits/iTens are captured into the digit latches on that same edge.
  - oFrame is high for the following cycle only.
- SHOW_U: oSeg = decode(latched units); oDigit enables bit0 only.
- SHOW_T: oSeg = decode(latched tens); oDigit enables bit1 only.
  - If BLANK_LEADING=1 and latched tens = 0: no digit is enabled and segments are all off.
- GAP_U/GAP_T: all segments off, no digit enabled.
- Decode, shown active-high {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - codes 10–15 (illegal BCD) display a dash = 1000000.
- Output polarity is applied after decode, per SEG_ACTIVE_LOW and DIG_ACTIVE_LOW.
- Input changes outside the frame-start edge have no effect until the next frame start.

## Timing
- Reset (asynchronous, while iRst_n = 0):
  - FSM = GAP_T, prescaler = 0, digit latches = 0.
  - oSeg all off (7'h7F when active-low), oDigit none enabled (2'b11 when active-low), oFrame = 0.
- After release, the first slot tick is the REFRESH_DIV-th rising edge. That edge enters SHOW_U, latches the digits, and updates oSeg/oDigit.
- oSeg, oDigit and oFrame are registered and change on the same edge as the FSM state.
- Slot length = REFRESH_DIV cycles; frame length = 4·REFRESH_DIV cycles.
- Reset asserted mid-slot:
  - Outputs go to their reset values immediately, without waiting for a clock.
  - The sequence restarts as after power-up.
- Only one digit is ever enabled. oDigit never shows both bits enabled in any cycle, including across transitions.

## Structure
- Shared package seg_pkg:
  - scan-state enum (SHOW_U, GAP_U, SHOW_T, GAP_T);
  - segment pattern constants for 0–9 and dash;
  - SEG_OFF constant.
- Sub-module bcd_to_seg: combinational 4-bit to 7-bit active-high decoder, instantiated once and fed through a mux of the two latched digits.
- Prescaler, FSM, latches and output registers stay in seven_seg_mux.

## Test plan
All scenarios use REFRESH_DIV=4 and default parameters unless stated.
- Reset then hold iUnits=7, iTens=3:
  - after 4 edges: oSeg=7'h78, oDigit=2'b10, oFrame=1 for one cycle;
  - +8 edges: oSeg=7'h30, oDigit=2'b01;
  - gap slots: oSeg=7'h7F, oDigit=2'b11.
- iTens=0, iUnits=5, BLANK_LEADING=1: SHOW_T slot gives oDigit=2'b11, oSeg=7'h7F. With BLANK_LEADING=0 the same slot gives oSeg=7'h40, oDigit=2'b01.
- iUnits=4'hC: SHOW_U slot gives oSeg=7'h3F (dash).
- Tearing: change iUnits 2→9 during SHOW_T. The next SHOW_U shows 9 (7'h10); the current frame keeps 2 until then; oFrame pulses exactly at frame start.
- Async reset asserted mid-SHOW_U with no clock edge: oSeg=7'h7F, oDigit=2'b11, oFrame=0 immediately. After release, the next SHOW_U occurs on the 4th edge.
- Polarity: SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=0, iUnits=8 gives oSeg=7'h7F, oDigit=2'b01 in SHOW_U. Over 1000 cycles, assert oDigit≠2'b11 every cycle.
